// File: rtl/qspi_rx_deser.sv
// Quad SPI receive deserialiser: packs 1/2/4 lane bits per sample strobe into a 1..DATA_W/8 byte word.
// Latency: word and done pulse appear 1 cycle after the final sample; no backpressure, strobes are consumed as they arrive.
module qspi_rx_deser #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               start_i,
  input  logic [1:0]                         mode_i,
  input  logic                               msb_first_i,
  input  logic [$clog2(DATA_W/8+1)-1:0]      len_i,
  input  logic                               sample_i,
  input  logic [3:0]                         qsd_i,
  input  logic                               abort_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               err_o,
  output logic [DATA_W-1:0]                  data_o
);

  localparam int LEN_W = $clog2(DATA_W/8+1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic                msb_q, msb_d;
  logic [CNT_W-1:0]    tgt_q, tgt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [CNT_W-1:0]    k;
  logic [3:0]          lanes;
  logic [DATA_W-1:0]   lanes_ext;
  logic                start_ok;

  // Single mode reads only qsd_i[1]; mode 3 is never latched so its arm is unreachable.
  always_comb begin
    k     = CNT_W'(4);
    lanes = qsd_i;
    case (mode_q)
      2'd0: begin k = CNT_W'(1); lanes = {3'b000, qsd_i[1]}; end
      2'd1: begin k = CNT_W'(2); lanes = {2'b00, qsd_i[1:0]}; end
      default: begin k = CNT_W'(4); lanes = qsd_i; end
    endcase
    lanes_ext = DATA_W'(lanes);
  end

  assign start_ok = (mode_i != 2'd3) && (len_i != '0) && (len_i <= LEN_W'(DATA_W/8));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    msb_d   = msb_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (start_ok) begin
            state_d = SHIFT;
            mode_d  = mode_i;
            msb_d   = msb_first_i;
            tgt_d   = CNT_W'(len_i) << 3;
            cnt_d   = '0;
            shreg_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (sample_i) begin
          cnt_d = cnt_q + k;
          // shreg starts cleared, so OR-ing into the free slot is an insert.
          shreg_d = msb_q ? ((shreg_q << k) | lanes_ext)
                          : (shreg_q | (lanes_ext << cnt_q));
          if (cnt_d == tgt_q) begin
            data_d  = shreg_d;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      mode_q  <= '0;
      msb_q   <= 1'b0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      msb_q   <= msb_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy_o = (state_q == SHIFT);
  assign done_o = done_q;
  assign err_o  = err_q;
  assign data_o = data_q;

endmodule

// File: tb/tb_qspi_rx_deser.sv
// Bench for qspi_rx_deser: bit-stream reference model checked every cycle, plus directed literal checks.
module tb_qspi_rx_deser;

  localparam int DATA_W = 32;
  localparam int LEN_W  = $clog2(DATA_W/8+1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_i;
  logic [1:0]        mode_i;
  logic              msb_first_i;
  logic [LEN_W-1:0]  len_i;
  logic              sample_i;
  logic [3:0]        qsd_i;
  logic              abort_i;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [DATA_W-1:0] data_o;

  int checks = 0;
  int errors = 0;

  qspi_rx_deser #(.DATA_W(DATA_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .mode_i(mode_i),
    .msb_first_i(msb_first_i), .len_i(len_i), .sample_i(sample_i),
    .qsd_i(qsd_i), .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .data_o(data_o)
  );

  always #5 clk = ~clk;

  // Reference: received bits are queued in arrival order and placed into the word at the end.
  bit                m_active;
  int                m_k;
  bit                m_msb;
  int                m_nbits;
  int                m_lane;
  bit                m_bits[$];
  logic              exp_busy, exp_done, exp_err;
  logic [DATA_W-1:0] exp_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0;
      m_bits.delete();
      exp_busy = 0; exp_done = 0; exp_err = 0; exp_data = '0;
    end else begin
      exp_done = 0;
      exp_err  = 0;
      if (!m_active) begin
        if (start_i) begin
          if (mode_i != 2'd3 && int'(len_i) >= 1 && int'(len_i) <= DATA_W/8) begin
            m_active = 1;
            m_k      = (mode_i == 2'd0) ? 1 : (mode_i == 2'd1) ? 2 : 4;
            m_msb    = msb_first_i;
            m_nbits  = int'(len_i) * 8;
            m_bits.delete();
          end else begin
            exp_err = 1;
          end
        end
      end else if (abort_i) begin
        m_active = 0;
      end else if (sample_i) begin
        for (int j = 0; j < m_k; j++) begin
          m_lane = m_msb ? (m_k - 1 - j) : j;
          m_bits.push_back(m_k == 1 ? qsd_i[1] : qsd_i[m_lane]);
        end
        if (m_bits.size() == m_nbits) begin
          exp_data = '0;
          foreach (m_bits[p]) exp_data[m_msb ? (m_nbits - 1 - p) : p] = m_bits[p];
          exp_done = 1;
          m_active = 0;
        end
      end
      exp_busy = m_active;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy", 64'(busy_o), 64'(exp_busy));
    chk("done", 64'(done_o), 64'(exp_done));
    chk("err",  64'(err_o),  64'(exp_err));
    chk("data", 64'(data_o), 64'(exp_data));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m, input logic msb, input logic [LEN_W-1:0] l);
    start_i = 1'b1; mode_i = m; msb_first_i = msb; len_i = l;
    step();
    start_i = 1'b0;
  endtask

  task automatic smp(input logic [3:0] v);
    sample_i = 1'b1; qsd_i = v;
    step();
    sample_i = 1'b0; qsd_i = 4'($urandom);
  endtask

  initial begin
    logic [7:0] a5;
    logic [3:0] dual_v[4];
    logic [3:0] nib_v[4];
    a5 = 8'hA5;
    dual_v = '{4'h2, 4'h1, 4'h3, 4'h0};
    nib_v  = '{4'hF, 4'h0, 4'h3, 4'hC};
    start_i = 0; mode_i = 0; msb_first_i = 0; len_i = '0;
    sample_i = 0; qsd_i = 0; abort_i = 0;
    rst_n = 1'b0;
    step(); step();
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);
    rst_n = 1'b1;
    step();

    // Quad MSB-first then LSB-first, nibbles 1..8
    do_start(2'd2, 1'b1, 3'd4);
    for (int i = 1; i <= 8; i++) smp(4'(i));
    chk("t1_done", 64'(done_o), 64'd1);
    chk("t1_data", 64'(data_o), 64'h12345678);
    step();
    chk("t1_done_clr", 64'(done_o), 64'd0);
    do_start(2'd2, 1'b0, 3'd4);
    for (int i = 1; i <= 8; i++) smp(4'(i));
    chk("t2_data", 64'(data_o), 64'h87654321);

    // Dual MSB-first with two idle cycles between strobes
    do_start(2'd1, 1'b1, 3'd1);
    for (int i = 0; i < 4; i++) begin
      smp(dual_v[i]);
      if (i < 3) begin
        step(); step();
        chk("t3_busy_gap", 64'(busy_o), 64'd1);
      end
    end
    chk("t3_done", 64'(done_o), 64'd1);
    chk("t3_data", 64'(data_o), 64'h9C);

    // Single lane 0xA5, then a quad LSB-first start during the done cycle
    do_start(2'd0, 1'b1, 3'd1);
    for (int i = 7; i >= 0; i--) smp({2'b00, a5[i], 1'b0});
    chk("t4_data", 64'(data_o), 64'hA5);
    chk("t4_done", 64'(done_o), 64'd1);
    do_start(2'd2, 1'b0, 3'd2);
    chk("t4_b2b_busy", 64'(busy_o), 64'd1);
    for (int i = 0; i < 4; i++) smp(nib_v[i]);
    chk("t4b_data", 64'(data_o), 64'hC30F);

    // Rejected starts
    step();
    do_start(2'd3, 1'b1, 3'd4);
    chk("t5_err_mode", 64'(err_o), 64'd1);
    chk("t5_busy_mode", 64'(busy_o), 64'd0);
    do_start(2'd2, 1'b1, 3'd0);
    chk("t5_err_len0", 64'(err_o), 64'd1);
    do_start(2'd2, 1'b1, 3'd5);
    chk("t5_err_len5", 64'(err_o), 64'd1);
    chk("t5_data", 64'(data_o), 64'hC30F);

    // Abort after three samples, and abort on the final sample
    do_start(2'd2, 1'b1, 3'd4);
    for (int i = 0; i < 3; i++) smp(4'hE);
    abort_i = 1'b1; step(); abort_i = 1'b0;
    chk("t6_busy", 64'(busy_o), 64'd0);
    chk("t6_data", 64'(data_o), 64'hC30F);
    do_start(2'd2, 1'b1, 3'd1);
    smp(4'h5);
    abort_i = 1'b1; smp(4'h6); abort_i = 1'b0;
    chk("t6b_done", 64'(done_o), 64'd0);
    chk("t6b_data", 64'(data_o), 64'hC30F);

    // Reset mid-transfer, then a clean transfer
    do_start(2'd2, 1'b1, 3'd4);
    for (int i = 0; i < 3; i++) smp(4'h9);
    rst_n = 1'b0;
    #1;
    chk("t7_busy", 64'(busy_o), 64'd0);
    chk("t7_data", 64'(data_o), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    do_start(2'd2, 1'b1, 3'd2);
    smp(4'hA); smp(4'hB); smp(4'hC); smp(4'hD);
    chk("t7_data_after", 64'(data_o), 64'hABCD);

    // Random traffic: starts in any state, gaps, aborts, bad configs
    for (int c = 0; c < 4000; c++) begin
      start_i     = ($urandom % 6) == 0;
      mode_i      = 2'($urandom);
      msb_first_i = 1'($urandom);
      len_i       = LEN_W'($urandom_range(0, 5));
      sample_i    = ($urandom % 3) != 0;
      qsd_i       = 4'($urandom);
      abort_i     = ($urandom % 60) == 0;
      step();
    end
    start_i = 0; sample_i = 0; abort_i = 0;
    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
